ftoi_pipe: RTL and testbench
============================

Name: ftoi_pipe

Overview:
- Converts an IEEE-754 single-precision operand to a signed 32-bit two's-complement integer; the inverse of the FPU's int-to-float path.
- Two-stage pipeline behind a valid/ready handshake, so the FPU issue logic can stall it.
- Serves the fcvt.w.s-style conversion op in the FPU execute slot.

Parameters:
ROUND_MODE, 0, rounding mode: 0 = round-to-nearest-even, 1 = round-toward-zero. Elaboration-time only.

Ports:
clk  input  1  clock; all state updates on its rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  x is valid this cycle
in_ready  output  1  block accepts x this cycle
x  input  32  float operand {sign, exp[7:0], man[22:0]}
out_valid  output  1  y holds a result
out_ready  input  1  consumer accepts y this cycle
y  output  32  signed integer result

Behaviour:
- Reset: one clock `clk`; reset `rstn` is asynchronous and active-low. While rstn=0: out_valid=0, y=0, stage-1 valid=0, all datapath registers 0.
- Reset mid-operation: in-flight results are discarded. The first out_valid after release is for an operand accepted after release.
- Advance enable: adv = !out_valid | out_ready.
  - in_ready = adv. This is combinational from out_ready and state, never from in_valid.
  - Handshake: a transfer occurs on an edge where valid & ready are both 1.
- Stage 1 (registered when adv), decode x:
  - Sign s.
  - Class: NaN (exp=255, man!=0); Inf (exp=255, man=0); zero/denormal (exp=0, flushed to zero); ovf (exp>=158); small (exp<126, |x|<0.5); normal.
  - Significand: 24-bit {1, man}.
  - exp >= 150: magnitude = sig << (exp-150). Exact, so g=r=st=0.
  - 126 <= exp < 150: magnitude = sig >> (150-exp). Keep guard = first dropped bit and sticky = OR of the remaining dropped bits.
  - small: magnitude=0, guard=0, sticky=1.
  - Stage-1 valid register loads in_valid when adv.
- Stage 2 (output register, loaded when adv):
  - RNE: inc = guard & (sticky | lsb).
  - RTZ: inc = 0.
  - mag2 = magnitude + inc, 32-bit unsigned.
  - y = s ? -mag2 : mag2.
  - out_valid loads stage-1 valid.
- Saturation overrides, in priority order:
  - NaN → 0x7FFFFFFF.
  - Inf or ovf: s=0 → 0x7FFFFFFF; s=1 → 0x80000000. This covers -2^31 exactly.
  - s=0 and mag2 > 0x7FFFFFFF → 0x7FFFFFFF. Unreachable for legal inputs but must be implemented.
  - Zero/denormal/small → 0 for either sign. Negative zero gives 0x00000000.
- Latency: 2 cycles from accept to out_valid when out_ready is held 1.
- Throughput: 1 result per cycle.
- Stall:
  - out_valid=1 and out_ready=0: y, out_valid and stage 1 all hold, and in_ready=0.
  - No result is lost or duplicated.
- Simultaneous events: out_ready=1 and in_valid=1 in the same cycle is a full pipeline shift. Bubbles (in_valid=0) propagate as out_valid=0.
- y is don't-care when out_valid=0, but must not contain X after reset.
- No exception flags are produced; flag generation belongs to the FPU status logic.

Decomposition:
- Package fpu_pkg:
  - Field widths: EXP_W=8, MAN_W=23.
  - BIAS=127.
  - Threshold constants: FTOI_EXP_EXACT=150, FTOI_EXP_OVF=158, FTOI_EXP_HALF=126.
  - INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000.
  - Rounding-mode enum: RM_RNE, RM_RTZ.
- One sub-module, ftoi_round (combinational). Takes magnitude, guard, sticky, sign and class; returns the final y.
- Decode and pipeline control stay in ftoi_pipe.

Test Plan:
- Exact values, out_ready=1: 0x3F800000 → 1; 0xC2F60000 (-123.0) → 0xFFFFFF85; 0x4EFFFFFF → 0x7FFFFF80. Each out_valid appears exactly 2 cycles after acceptance.
- Rounding with ROUND_MODE=0:
  - 0x3F000000 (0.5) → 0; 0x3F400000 (0.75) → 1
  - 0x40200000 (2.5) → 2; 0x40600000 (3.5) → 4
  - 0xC0200000 (-2.5) → 0xFFFFFFFE
- Rounding with ROUND_MODE=1: the same five inputs → 0, 0, 2, 3, 0xFFFFFFFE.
- Specials:
  - 0x4F000000 → 0x7FFFFFFF; 0xCF000000 → 0x80000000
  - 0x7FC00000 → 0x7FFFFFFF; 0xFF800000 → 0x80000000
  - 0x80000000 → 0; 0x00000001 → 0
- Back-to-back stream of 8 operands with out_ready toggled 1,0,0,1,… in a random pattern:
  - Results appear in order, none dropped or duplicated.
  - in_ready=0 whenever out_valid=1 and out_ready=0.
  - y stays stable while stalled.
- Reset: assert rstn=0 asynchronously between clock edges while two operands are in flight.
  - out_valid and y go to 0 immediately.
  - After release, out_valid is first seen 2 cycles after the next accepted operand, with the correct value for that operand.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and types for the FPU conversion datapaths.
//   Field widths, exponent bias, float-to-int exponent thresholds,
//   saturation limits, rounding-mode and operand-class encodings.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // Exponent at or above which the integer is exact (no fraction bits left).
  localparam logic [EXP_W-1:0] FTOI_EXP_EXACT = EXP_W'(BIAS + MAN_W);
  // |x| >= 2^31: does not fit a signed 32-bit integer (except -2^31, which
  // saturates to the same value anyway).
  localparam logic [EXP_W-1:0] FTOI_EXP_OVF   = EXP_W'(BIAS + 31);
  // Below this exponent |x| < 0.5, so the result is always zero.
  localparam logic [EXP_W-1:0] FTOI_EXP_HALF  = EXP_W'(BIAS - 1);

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rmode_e;

  // Operand class after decode. FC_NORM is the all-zero encoding so a
  // reset stage-1 register reads as an ordinary zero magnitude.
  typedef enum logic [2:0] {
    FC_NORM  = 3'd0,
    FC_ZERO  = 3'd1,
    FC_SMALL = 3'd2,
    FC_OVF   = 3'd3,
    FC_INF   = 3'd4,
    FC_NAN   = 3'd5
  } fclass_e;

endpackage

// File: rtl/ftoi_round.sv
// ftoi_round: combinational rounding, negation and saturation for the
// float-to-int converter.
//   mag  : integer part of |x| (unsigned)
//   grd  : first bit below the integer lsb
//   stk  : OR of all lower discarded bits
//   sgn  : sign of x
//   cls  : operand class (fclass_e encoding)
//   y    : final signed 32-bit result
module ftoi_round
  import fpu_pkg::*;
#(
  parameter int ROUND_MODE = 0
) (
  input  logic [31:0] mag,
  input  logic        grd,
  input  logic        stk,
  input  logic        sgn,
  input  logic [2:0]  cls,
  output logic [31:0] y
);

  localparam rmode_e RM = (ROUND_MODE == 0) ? RM_RNE : RM_RTZ;

  function automatic logic rnd_inc(input logic g, input logic s, input logic lsb);
    if (RM == RM_RNE) return g & (s | lsb);
    else              return 1'b0;
  endfunction

  // Overrides in priority order; the positive-overflow check guards the
  // signed range even though decode never produces such a magnitude.
  function automatic logic [31:0] sat(input logic sg, input logic [2:0] c,
                                      input logic [31:0] m2);
    logic signed [31:0] sv;
    sv = sg ? -$signed(m2) : $signed(m2);
    if (c == FC_NAN)                  return INT_MAX;
    if (c == FC_INF || c == FC_OVF)   return sg ? INT_MIN : INT_MAX;
    if (!sg && (m2 > INT_MAX))        return INT_MAX;
    if (c == FC_ZERO || c == FC_SMALL) return '0;
    return sv;
  endfunction

  logic [31:0] mag2;

  assign mag2 = mag + {31'b0, rnd_inc(grd, stk, mag[0])};
  assign y    = sat(sgn, cls, mag2);

endmodule

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage IEEE-754 single to signed 32-bit integer converter
// with valid/ready flow control.
//   clk       : clock, rising edge
//   rstn      : asynchronous active-low reset
//   in_valid  : x is valid
//   in_ready  : x is accepted this cycle (depends only on state/out_ready)
//   x         : float operand {sign, exp[7:0], man[22:0]}
//   out_valid : y holds a result
//   out_ready : consumer takes y this cycle
//   y         : signed integer result
// ROUND_MODE: 0 = round-to-nearest-even, 1 = round-toward-zero.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  logic                  adv;
  logic [EXP_W-1:0]      exp_d;
  logic [MAN_W-1:0]      man_d;
  logic [MAN_W:0]        sig_d;
  logic [EXP_W-1:0]      lsh_d;
  logic [EXP_W-1:0]      rsh_d;
  logic [47:0]           ext_d;
  fclass_e               cls_d;
  logic [31:0]           mag_d;
  logic                  grd_d;
  logic                  stk_d;

  logic                  vld_p1;
  logic                  sgn_p1;
  fclass_e               cls_p1;
  logic [31:0]           mag_p1;
  logic                  grd_p1;
  logic                  stk_p1;

  logic                  vld_p2;
  logic [31:0]           y_p2;
  logic [31:0]           y_rnd;

  // The whole pipe moves together: any empty or draining output slot lets
  // every stage advance, so no result can be overwritten while stalled.
  assign adv      = !vld_p2 | out_ready;
  assign in_ready = adv;

  assign exp_d = x[30:23];
  assign man_d = x[22:0];
  assign sig_d = {1'b1, man_d};
  assign lsh_d = exp_d - FTOI_EXP_EXACT;
  assign rsh_d = FTOI_EXP_EXACT - exp_d;
  // Right-align the significand with 24 spare bits below it so the
  // discarded fraction lands in ext_d[23:0] for guard/sticky extraction.
  assign ext_d = {sig_d, 24'b0} >> rsh_d;

  always_comb begin
    cls_d = FC_NORM;
    mag_d = '0;
    grd_d = 1'b0;
    stk_d = 1'b0;
    if (exp_d == '1) begin
      cls_d = (man_d != '0) ? FC_NAN : FC_INF;
    end else if (exp_d == '0) begin
      cls_d = FC_ZERO;
    end else if (exp_d >= FTOI_EXP_OVF) begin
      cls_d = FC_OVF;
    end else if (exp_d < FTOI_EXP_HALF) begin
      cls_d = FC_SMALL;
      stk_d = 1'b1;
    end else if (exp_d >= FTOI_EXP_EXACT) begin
      mag_d = {8'b0, sig_d} << lsh_d;
    end else begin
      mag_d = {8'b0, ext_d[47:24]};
      grd_d = ext_d[23];
      stk_d = |ext_d[22:0];
    end
  end

  // ---- stage 1: decoded operand ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      sgn_p1 <= 1'b0;
      cls_p1 <= FC_NORM;
      mag_p1 <= '0;
      grd_p1 <= 1'b0;
      stk_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
      sgn_p1 <= x[31];
      cls_p1 <= cls_d;
      mag_p1 <= mag_d;
      grd_p1 <= grd_d;
      stk_p1 <= stk_d;
    end
  end

  ftoi_round #(
    .ROUND_MODE (ROUND_MODE)
  ) u_round (
    .mag (mag_p1),
    .grd (grd_p1),
    .stk (stk_p1),
    .sgn (sgn_p1),
    .cls (cls_p1),
    .y   (y_rnd)
  );

  // ---- stage 2: rounded, saturated result ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2 <= 1'b0;
      y_p2   <= '0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      y_p2   <= y_rnd;
    end
  end

  assign out_valid = vld_p2;
  assign y         = y_p2;

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe: scoreboard bench for ftoi_pipe. Two instances (RNE and RTZ)
// share the same stimulus; each accepted operand pushes both expected
// results, which are popped and compared when the output handshakes.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] y0, y1;

  always #5 clk = ~clk;

  ftoi_pipe #(.ROUND_MODE(0)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0), .x(x),
    .out_valid(out_valid0), .out_ready(out_ready), .y(y0));

  ftoi_pipe #(.ROUND_MODE(1)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1), .x(x),
    .out_valid(out_valid1), .out_ready(out_ready), .y(y1));

  typedef struct {
    logic [31:0] x;
    logic [31:0] e0;
    logic [31:0] e1;
    int          cyc;
    bit          lat;
  } sb_t;

  sb_t         sbq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          rnd_mode = 1'b0;
  logic [31:0] cur_e0, cur_e1;

  // operand, expected RNE result, expected RTZ result
  localparam int N = 17;
  logic [31:0] tx [N] = '{32'h3F800000, 32'hC2F60000, 32'h4EFFFFFF, 32'h3F000000,
                          32'h3F400000, 32'h40200000, 32'h40600000, 32'hC0200000,
                          32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'hFF800000,
                          32'h80000000, 32'h00000001, 32'hBF400000, 32'h7F800000,
                          32'hCEFFFFFF};
  logic [31:0] te0 [N] = '{32'h00000001, 32'hFFFFFF85, 32'h7FFFFF80, 32'h00000000,
                           32'h00000001, 32'h00000002, 32'h00000004, 32'hFFFFFFFE,
                           32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
                           32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF,
                           32'h80000080};
  logic [31:0] te1 [N] = '{32'h00000001, 32'hFFFFFF85, 32'h7FFFFF80, 32'h00000000,
                           32'h00000000, 32'h00000002, 32'h00000003, 32'hFFFFFFFE,
                           32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
                           32'h00000000, 32'h00000000, 32'h00000000, 32'h7FFFFFFF,
                           32'h80000080};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Consumer readiness: held high in directed phases, random in stream phase.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    bit          stall_prev;
    logic [31:0] y0_prev, y1_prev;
    sb_t         e;
    stall_prev = 1'b0;
    y0_prev = '0;
    y1_prev = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (stall_prev) begin
          chk("stall_vld", 32'(out_valid0), 32'd1);
          chk("stall_y_rne", y0, y0_prev);
          chk("stall_y_rtz", y1, y1_prev);
        end
        chk("vld_match", 32'(out_valid1), 32'(out_valid0));
        if (out_valid0) begin
          chk("in_ready_busy", 32'(in_ready0), 32'(out_ready));
          if (out_ready) begin
            if (sbq.size() == 0) begin
              chk("extra_out", 32'(sbq.size()), 32'd1);
            end else begin
              e = sbq.pop_front();
              chk($sformatf("rne_%08h", e.x), y0, e.e0);
              chk($sformatf("rtz_%08h", e.x), y1, e.e1);
              if (e.lat) chk($sformatf("lat_%08h", e.x), 32'(cyc - e.cyc), 32'd2);
            end
          end
        end else begin
          chk("in_ready_idle", 32'(in_ready0), 32'd1);
        end
        stall_prev = out_valid0 && !out_ready;
        y0_prev = y0;
        y1_prev = y1;
        if (in_valid && in_ready0) begin
          e.x = x;
          e.e0 = cur_e0;
          e.e1 = cur_e1;
          e.cyc = cyc;
          e.lat = !rnd_mode;
          sbq.push_back(e);
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Present one operand; returns at the falling edge before its accept edge.
  task automatic send(input int idx);
    bit acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x = tx[idx];
    cur_e0 = te0[idx];
    cur_e1 = te1[idx];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready0) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    x = '0;
    cur_e0 = '0;
    cur_e1 = '0;
    #1;
    chk("reset_vld", 32'(out_valid0), 32'd0);
    chk("reset_y_rne", y0, 32'd0);
    chk("reset_y_rtz", y1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Directed values, back-to-back with the consumer always ready.
    for (int i = 0; i < N; i++) send(i);
    idle(3);
    drain();

    // Isolated operand with bubbles around it.
    send(6);
    idle(4);
    drain();

    // Random consumer stalls over a back-to-back stream.
    rnd_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(int'($urandom_range(0, N - 1)));
    idle(2);
    drain();
    rnd_mode = 1'b0;
    repeat (3) @(posedge clk);

    // Reset with two operands in flight.
    send(0);
    send(1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_vld", 32'(out_valid0), 32'd0);
    chk("midrst_y_rne", y0, 32'd0);
    chk("midrst_y_rtz", y1, 32'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);
    send(7);
    idle(4);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
